// File: rtl/rps_match_scorer_if.sv
// Round handshake between the rock-paper-scissors judge and the match scorer:
// one-hot verdict qualified by round_valid, with acceptance and rejection feedback.
interface rps_match_scorer_if;
  logic round_valid;
  logic p1wins;
  logic p2wins;
  logic tied;
  logic round_ready;
  logic bad_round;

  modport master (
    output round_valid,
    output p1wins,
    output p2wins,
    output tied,
    input  round_ready,
    input  bad_round
  );

  modport slave (
    input  round_valid,
    input  p1wins,
    input  p2wins,
    input  tied,
    output round_ready,
    output bad_round
  );
endinterface

// File: rtl/rps_match_scorer.sv
// First-to-N scorekeeper fed by the RPS judge; holds the result until a new start.
// Optional RPS_TIE_LIMIT_EN adds a draw once MAX_ROUNDS legal rounds pass with no champion.
module rps_match_scorer #(
  parameter int WINS_TO_MATCH = 3,
  parameter int SCORE_W       = 3,
  parameter int ROUND_W       = 4,
  parameter int MAX_ROUNDS    = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  rps_match_scorer_if.slave  bus,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] tie_count,
  output logic [ROUND_W-1:0] round_count,
  output logic               match_over,
  output logic               p1_champ,
  output logic               p2_champ,
  output logic               match_draw
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(WINS_TO_MATCH);
  localparam logic [SCORE_W-1:0] TIE_SAT    = '1;
  localparam logic [ROUND_W-1:0] ROUND_SAT  = '1;

  state_t state, state_n;

  logic               round_ready_q, bad_round_q;
  logic               legal, take_round;
  logic               p1_hit, p2_hit, limit_hit;
  logic [SCORE_W-1:0] p1_inc, p2_inc, tie_inc;
  logic [ROUND_W-1:0] round_inc;

  logic [SCORE_W-1:0] p1_score_n, p2_score_n, tie_count_n;
  logic [ROUND_W-1:0] round_count_n;
  logic               round_ready_n, bad_round_n, match_over_n;
  logic               p1_champ_n, p2_champ_n, match_draw_n;

  assign bus.round_ready = round_ready_q;
  assign bus.bad_round   = bad_round_q;

  assign legal = (bus.p1wins & ~bus.p2wins & ~bus.tied) |
                 (~bus.p1wins & bus.p2wins & ~bus.tied) |
                 (~bus.p1wins & ~bus.p2wins & bus.tied);

  // start wins over a same-cycle verdict, so that round is simply dropped
  assign take_round = (state == PLAY) & bus.round_valid & ~start;

  assign p1_inc    = p1_score + SCORE_W'(1);
  assign p2_inc    = p2_score + SCORE_W'(1);
  assign tie_inc   = (tie_count == TIE_SAT) ? tie_count : tie_count + SCORE_W'(1);
  assign round_inc = (round_count == ROUND_SAT) ? round_count : round_count + ROUND_W'(1);

  assign p1_hit = take_round & legal & bus.p1wins & (p1_inc == WIN_TARGET);
  assign p2_hit = take_round & legal & bus.p2wins & (p2_inc == WIN_TARGET);

`ifdef RPS_TIE_LIMIT_EN
  localparam logic [ROUND_W-1:0] ROUND_LIMIT = ROUND_W'(MAX_ROUNDS);
  // A champion on the limit round outranks the draw
  assign limit_hit = take_round & legal & ~p1_hit & ~p2_hit & (round_inc == ROUND_LIMIT);
`else
  localparam int unused_max_rounds = MAX_ROUNDS;
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      p1_score      <= '0;
      p2_score      <= '0;
      tie_count     <= '0;
      round_count   <= '0;
      round_ready_q <= 1'b0;
      bad_round_q   <= 1'b0;
      match_over    <= 1'b0;
      p1_champ      <= 1'b0;
      p2_champ      <= 1'b0;
      match_draw    <= 1'b0;
    end else begin
      state         <= state_n;
      p1_score      <= p1_score_n;
      p2_score      <= p2_score_n;
      tie_count     <= tie_count_n;
      round_count   <= round_count_n;
      round_ready_q <= round_ready_n;
      bad_round_q   <= bad_round_n;
      match_over    <= match_over_n;
      p1_champ      <= p1_champ_n;
      p2_champ      <= p2_champ_n;
      match_draw    <= match_draw_n;
    end
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = PLAY;
    end else if (p1_hit | p2_hit | limit_hit) begin
      state_n = DONE;
    end
  end

  // Registered outputs are derived from next state so they line up with it
  always_comb begin
    p1_score_n    = p1_score;
    p2_score_n    = p2_score;
    tie_count_n   = tie_count;
    round_count_n = round_count;
    p1_champ_n    = p1_champ;
    p2_champ_n    = p2_champ;
    match_draw_n  = match_draw;
    bad_round_n   = 1'b0;
    if (start) begin
      p1_score_n    = '0;
      p2_score_n    = '0;
      tie_count_n   = '0;
      round_count_n = '0;
      p1_champ_n    = 1'b0;
      p2_champ_n    = 1'b0;
      match_draw_n  = 1'b0;
    end else if (take_round) begin
      if (legal) begin
        if (bus.p1wins) p1_score_n = p1_inc;
        if (bus.p2wins) p2_score_n = p2_inc;
        if (bus.tied)   tie_count_n = tie_inc;
        round_count_n = round_inc;
        p1_champ_n    = p1_hit;
        p2_champ_n    = p2_hit;
        match_draw_n  = limit_hit;
      end else begin
        bad_round_n = 1'b1;
      end
    end
    round_ready_n = (state_n == PLAY);
    match_over_n  = (state_n == DONE);
  end

endmodule
